// File: rtl/bc_orbit_ctrl.sv
// Orbit-level controller for the bunch counter: locks BC to the orbit
// marker, polices sync, counts orbits and gates the readout window.
module bc_orbit_ctrl #(
  parameter int BC_W      = 12,
  parameter int ORBIT_LEN = 3564,
  parameter int ORB_W     = 24,
  parameter int MISS_MAX  = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic             SYNC_IN,
  input  logic [BC_W-1:0]  BC,
  input  logic [BC_W-1:0]  WIN_START,
  input  logic [BC_W-1:0]  WIN_LEN,
  input  logic             ERR_CLR,
  output logic             BC_CLR,
  output logic             BC0,
  output logic             WINDOW,
  output logic [ORB_W-1:0] ORBIT,
  output logic             LOCKED,
  output logic             SYNC_ERR,
  output logic [1:0]       STATE
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    RUN       = 2'd2,
    ERROR     = 2'd3
  } state_t;

  localparam int PRE_I  = ORBIT_LEN - 2;
  localparam int LAST_I = ORBIT_LEN - 1;
  localparam logic [BC_W:0] PRE  = PRE_I[BC_W:0];
  localparam logic [BC_W:0] LAST = LAST_I[BC_W:0];
  localparam logic [3:0]    MISS_LIM = MISS_MAX[3:0];

  state_t          state;
  state_t          nxt;
  logic [3:0]      miss_cnt;
  logic [3:0]      miss_nxt;
  logic [BC_W-1:0] s_start;
  logic [BC_W-1:0] s_len;
  logic            first_bc0;
  logic            at_pre;
  logic            err_ev;
  logic            in_win;
  logic            clr_nxt;
  logic            bc0_nxt;
  logic [BC_W:0]   bc_ext;
  logic [BC_W:0]   win_end;
  logic [BC_W:0]   win_hi;

  assign STATE = state;

  always_comb begin
    bc_ext  = {1'b0, BC};
    at_pre  = (bc_ext == PRE);
    // one extra bit keeps the window end from wrapping into the next orbit
    win_end = {1'b0, s_start} + {1'b0, s_len} - 1'b1;
    win_hi  = (win_end < LAST) ? win_end : LAST;
    in_win  = (s_len != '0) && (bc_ext >= {1'b0, s_start})
           && (bc_ext <= win_hi);
    miss_nxt = miss_cnt;
    err_ev   = 1'b0;
    nxt      = state;
    unique case (state)
      IDLE:      nxt = WAIT_SYNC;
      WAIT_SYNC: if (SYNC_IN) nxt = RUN;
      RUN: begin
        if (SYNC_IN) begin
          if (!at_pre) err_ev = 1'b1;
          else miss_nxt = '0;
        end else if (at_pre) begin
          miss_nxt = miss_cnt + 1'b1;
          if (miss_nxt >= MISS_LIM) err_ev = 1'b1;
        end
        if (err_ev) nxt = ERROR;
      end
      ERROR:     if (ERR_CLR) nxt = WAIT_SYNC;
    endcase
    if (!ENABLE) nxt = IDLE;
    clr_nxt = (nxt != RUN) || (state != RUN) || at_pre;
    bc0_nxt = BC_CLR && (state == RUN) && (nxt == RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      BC_CLR    <= 1'b1;
      BC0       <= 1'b0;
      WINDOW    <= 1'b0;
      ORBIT     <= '0;
      LOCKED    <= 1'b0;
      SYNC_ERR  <= 1'b0;
      miss_cnt  <= '0;
      s_start   <= '0;
      s_len     <= '0;
      first_bc0 <= 1'b0;
    end else begin
      state    <= nxt;
      BC_CLR   <= clr_nxt;
      BC0      <= bc0_nxt;
      LOCKED   <= (nxt == RUN);
      WINDOW   <= (state == RUN) && (nxt == RUN) && in_win;
      miss_cnt <= miss_nxt;
      if (ENABLE && err_ev)
        SYNC_ERR <= 1'b1;
      else if (ENABLE && state == ERROR && ERR_CLR)
        SYNC_ERR <= 1'b0;
      if (nxt == RUN && state != RUN) begin
        ORBIT     <= '0;
        miss_cnt  <= '0;
        first_bc0 <= 1'b1;
        s_start   <= WIN_START;
        s_len     <= WIN_LEN;
      end else if (bc0_nxt) begin
        s_start <= WIN_START;
        s_len   <= WIN_LEN;
        // the orbit that starts at lock is orbit 0
        if (first_bc0) first_bc0 <= 1'b0;
        else ORBIT <= ORBIT + 1'b1;
      end
      if (nxt == IDLE) ORBIT <= '0;
    end
  end

endmodule

// File: doc/bc_orbit_ctrl.md
Name: bc_orbit_ctrl

Overview:
- Orbit-level controller for the 12-bit bunch counter, which has 1-cycle latency: its RST high at an edge gives BC=0 the next cycle, otherwise BC increments.
- Drives the counter's synchronous clear (BC_CLR) and aligns BC to an external orbit marker (SYNC_IN).
- Enforces the orbit length, detects sync loss or misalignment, counts orbits and generates a programmable per-orbit readout window for the digitizer datapath.

Parameters:
- BC_W, 12, bunch counter width.
- ORBIT_LEN, 3564, BCs per orbit; legal range 4..2^BC_W.
- ORB_W, 24, orbit counter width.
- MISS_MAX, 3, consecutive missing SYNC_IN markers that force ERROR; legal range 1..15.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- ENABLE  in  1  run request; low returns the block to IDLE.
- SYNC_IN  in  1  orbit marker, 1-cycle pulse.
- BC  in  BC_W  current bunch counter value.
- WIN_START  in  BC_W  first BC of the readout window.
- WIN_LEN  in  BC_W  window length in BCs; 0 disables the window.
- ERR_CLR  in  1  clears SYNC_ERR and leaves ERROR.
- BC_CLR  out  1  registered; drives the bunch counter's RST.
- BC0  out  1  registered 1-cycle pulse, high in the cycle BC==0 while in RUN.
- WINDOW  out  1  registered readout-window gate.
- ORBIT  out  ORB_W  orbit count.
- LOCKED  out  1  high in RUN.
- SYNC_ERR  out  1  sticky error flag.
- STATE  out  2  IDLE=0, WAIT_SYNC=1, RUN=2, ERROR=3.

Behaviour:
- Reset values: STATE=IDLE, BC_CLR=1, BC0=0, WINDOW=0, ORBIT=0, LOCKED=0, SYNC_ERR=0, miss counter=0, shadow window registers=0. Reset overrides every other input.
- Priority per cycle: RST, then ENABLE=0 (next state IDLE from any state), then the state transitions below.
- IDLE: BC_CLR=1, ORBIT held at 0. ENABLE=1 -> WAIT_SYNC.
- WAIT_SYNC: BC_CLR=1.
  - SYNC_IN=1 in cycle t -> RUN at t+1.
  - BC_CLR stays 1 in cycle t+1, so BC=0 at t+2.
  - On this transition: ORBIT cleared to 0, miss counter cleared, WIN_START/WIN_LEN loaded into shadow registers.
- RUN: BC_CLR is registered high for exactly the cycle in which BC==ORBIT_LEN-1, i.e. set when BC==ORBIT_LEN-2.
  - Resulting BC sequence: ..., ORBIT_LEN-1, 0.
  - BC0 = BC_CLR delayed one cycle, gated by RUN. The first BC0 comes at t+2 after the locking SYNC_IN.
- SYNC_IN alignment in RUN:
  - Aligned SYNC_IN coincides with BC==ORBIT_LEN-2.
  - Aligned SYNC_IN: miss counter -> 0.
  - SYNC_IN with BC!=ORBIT_LEN-2: SYNC_ERR=1, next state ERROR.
  - BC==ORBIT_LEN-2 without SYNC_IN: miss counter +1. Reaching MISS_MAX sets SYNC_ERR=1 and moves to ERROR.
  - Simultaneous SYNC_IN and BC==ORBIT_LEN-2 counts as aligned, not as a miss.
- ORBIT: increments by 1, wrapping at 2^ORB_W, in each cycle BC0=1 except the first BC0 after locking, so the first orbit is 0. Holds in ERROR; cleared in IDLE.
- Window shadow registers: reloaded at every BC0 and on entry to RUN. Input changes mid-orbit take effect at the next orbit.
- WINDOW:
  - WINDOW(c+1) = RUN(c) and sWIN_LEN!=0 and sWIN_START <= BC(c) <= min(sWIN_START+sWIN_LEN-1, ORBIT_LEN-1).
  - The sum is computed at BC_W+1 bits, so there is no wrap into the next orbit.
  - WIN_START >= ORBIT_LEN: never asserts.
- ERROR: BC_CLR=1, LOCKED=0, WINDOW=0, BC0=0. ERR_CLR=1 -> SYNC_ERR=0, next state WAIT_SYNC. ERR_CLR outside ERROR has no effect.
- LOCKED is registered from the next state, so LOCKED=1 exactly when STATE=RUN.
- ENABLE=0 mid-RUN: IDLE at the next cycle, BC_CLR=1 that cycle, ORBIT=0, SYNC_ERR preserved.

Test Plan:
- Lock and orbit timing (ORBIT_LEN=16): RST, ENABLE=1, SYNC_IN pulse at t -> STATE=RUN at t+1, BC=0 and BC0=1 at t+2, BC wraps 15->0 with BC0 every 16 cycles, ORBIT=0,1,2 at successive BC0s.
- Steady aligned sync: SYNC_IN pulses at BC==14 for 5 orbits -> SYNC_ERR=0, LOCKED=1 throughout, ORBIT=4.
- Misaligned sync: SYNC_IN at BC==7 -> SYNC_ERR=1, STATE=ERROR next cycle, BC_CLR=1; ERR_CLR -> WAIT_SYNC, SYNC_ERR=0; new SYNC_IN relocks.
- Missed markers (MISS_MAX=3): stop SYNC_IN -> error raised at the third BC==14 without sync; 2 misses followed by a good marker -> no error.
- Window, truncation and reload (ORBIT_LEN=16):
  - WIN_START=3, WIN_LEN=4 -> WINDOW high while delayed BC is 3..6, i.e. cycles after BC 3..6.
  - WIN_START=13, WIN_LEN=8 -> WINDOW high for BC 13..15 only.
  - WIN_LEN=0 -> WINDOW never asserts.
  - Changing WIN_START mid-orbit takes effect only after the next BC0.
- Reset and disable mid-run: RST at BC==9 -> all outputs at reset values the next cycle; ENABLE=0 in RUN -> IDLE, ORBIT=0, BC_CLR=1 held.
